lap_recorder: RTL and testbench

Split-time capture and display sequencer for the stopwatch. It sits between the time counter and the display driver, alongside the stopwatch control FSM, and consumes that FSM's `init_regs` and `count_enabled` outputs. While counting, a split pulse freezes the display and stores the current time in a small lap buffer. While paused, recall pulses step the display through the stored laps, oldest first.

---
 rtl/lap_recorder.sv | 164 ++++++++++++++++
 tb/tb_lap_recorder.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/lap_recorder.sv
// Split-time capture and display sequencer: freezes the display on split, buffers laps, replays them on recall.
// Optional overwrite-oldest ring behaviour when full is enabled by defining LAP_RING_EN.
module lap_recorder #(
  parameter int unsigned TIME_W = 16,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_regs,
  input  logic              count_enabled,
  input  logic              split,
  input  logic              recall,
  input  logic [TIME_W-1:0] time_in,
  output logic [TIME_W-1:0] disp_time,
  output logic [IDX_W-1:0]  lap_idx,
  output logic [IDX_W:0]    lap_count,
  output logic              frozen,
  output logic              recalling,
  output logic              overflow
);

  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    LIVE   = 2'd0,
    FROZEN = 2'd1,
    RECALL = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [TIME_W-1:0]  lap_mem [DEPTH];
  logic [TIME_W-1:0]  hold, hold_nxt, disp_nxt;
  logic [IDX_W-1:0]   wr_ptr, wr_ptr_nxt, oldest, rd_ptr, idx_nxt;
  logic [CNT_W-1:0]   count_nxt;
  logic               ovf_nxt, mem_we, full, capture, can_recall;

  assign full       = (lap_count == CNT_W'(DEPTH));
  assign capture    = split && count_enabled;
  assign can_recall = recall && !count_enabled && (lap_count != '0);
  assign rd_ptr     = oldest + lap_idx;

`ifdef LAP_RING_EN
  logic [IDX_W-1:0] oldest_nxt;

  // Oldest pointer advances when a full buffer is overwritten
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) oldest <= '0;
    else        oldest <= oldest_nxt;
  end
`else
  assign oldest = '0;
`endif

  // Next-state and datapath decode
  always_comb begin
    state_nxt  = state;
    disp_nxt   = disp_time;
    idx_nxt    = lap_idx;
    count_nxt  = lap_count;
    ovf_nxt    = overflow;
    hold_nxt   = hold;
    wr_ptr_nxt = wr_ptr;
    mem_we     = 1'b0;
`ifdef LAP_RING_EN
    oldest_nxt = oldest;
`endif
    if (init_regs) begin
      state_nxt  = LIVE;
      disp_nxt   = time_in;
      idx_nxt    = '0;
      count_nxt  = '0;
      ovf_nxt    = 1'b0;
      wr_ptr_nxt = '0;
`ifdef LAP_RING_EN
      oldest_nxt = '0;
`endif
    end else begin
      case (state)
        LIVE: begin
          disp_nxt = time_in;
          if (capture) begin
            state_nxt = FROZEN;
            hold_nxt  = time_in;
            if (!full) begin
              mem_we     = 1'b1;
              wr_ptr_nxt = wr_ptr + IDX_W'(1);
              count_nxt  = lap_count + CNT_W'(1);
            end else begin
              ovf_nxt = 1'b1;
`ifdef LAP_RING_EN
              // Full ring: write pointer equals oldest, so this overwrites the oldest lap
              mem_we     = 1'b1;
              wr_ptr_nxt = wr_ptr + IDX_W'(1);
              oldest_nxt = oldest + IDX_W'(1);
`endif
            end
          end else if (can_recall) begin
            state_nxt = RECALL;
            idx_nxt   = '0;
          end
        end
        FROZEN: begin
          disp_nxt = hold;
          if (capture) begin
            state_nxt = LIVE;
          end else if (can_recall) begin
            state_nxt = RECALL;
            idx_nxt   = '0;
          end
        end
        RECALL: begin
          disp_nxt = lap_mem[rd_ptr];
          if (count_enabled) begin
            state_nxt = LIVE;
            idx_nxt   = '0;
          end else if (recall) begin
            if ((CNT_W'(lap_idx) + CNT_W'(1)) < lap_count) begin
              idx_nxt = lap_idx + IDX_W'(1);
            end else begin
              state_nxt = LIVE;
              idx_nxt   = '0;
            end
          end
        end
        default: begin
          state_nxt = LIVE;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LIVE;
      disp_time <= '0;
      lap_idx   <= '0;
      lap_count <= '0;
      overflow  <= 1'b0;
      hold      <= '0;
      wr_ptr    <= '0;
      frozen    <= 1'b0;
      recalling <= 1'b0;
    end else begin
      state     <= state_nxt;
      disp_time <= disp_nxt;
      lap_idx   <= idx_nxt;
      lap_count <= count_nxt;
      overflow  <= ovf_nxt;
      hold      <= hold_nxt;
      wr_ptr    <= wr_ptr_nxt;
      frozen    <= (state_nxt == FROZEN);
      recalling <= (state_nxt == RECALL);
    end
  end

  // Lap storage needs no reset; entries are only read after being written
  always_ff @(posedge clk) begin
    if (mem_we) lap_mem[wr_ptr] <= time_in;
  end

endmodule

// File: tb/tb_lap_recorder.sv
// Self-checking bench for lap_recorder: per-cycle vector table plus overflow, recall and async-reset sequences.
module tb_lap_recorder;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_regs, count_enabled, split, recall;
  logic [15:0] time_in;
  logic [15:0] disp_time;
  logic [1:0]  lap_idx;
  logic [2:0]  lap_count;
  logic        frozen, recalling, overflow;

  int tests  = 0;
  int failed = 0;

  lap_recorder #(.TIME_W(16), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .init_regs(init_regs), .count_enabled(count_enabled),
    .split(split), .recall(recall), .time_in(time_in), .disp_time(disp_time),
    .lap_idx(lap_idx), .lap_count(lap_count), .frozen(frozen),
    .recalling(recalling), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ce, sp, rc, ini;
    logic [15:0] t;
    logic [15:0] disp;
    logic [1:0]  idx;
    logic [2:0]  cnt;
    logic        frz, rec, ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic ce, logic sp, logic rc, logic ini, logic [15:0] t,
                               logic [15:0] disp, logic [1:0] idx, logic [2:0] cnt,
                               logic frz, logic rec);
    vec_t v;
    v.ce = ce; v.sp = sp; v.rc = rc; v.ini = ini; v.t = t;
    v.disp = disp; v.idx = idx; v.cnt = cnt; v.frz = frz; v.rec = rec; v.ovf = 1'b0;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input int row, input logic [15:0] disp, input logic [1:0] idx,
                         input logic [2:0] cnt, input logic frz, input logic rec, input logic ovf);
    chk("disp_time", row, 32'(disp_time), 32'(disp));
    chk("lap_idx",   row, 32'(lap_idx),   32'(idx));
    chk("lap_count", row, 32'(lap_count), 32'(cnt));
    chk("frozen",    row, 32'(frozen),    32'(frz));
    chk("recalling", row, 32'(recalling), 32'(rec));
    chk("overflow",  row, 32'(overflow),  32'(ovf));
  endtask

  logic [15:0] exp_laps [4];

  initial begin
    reset = 1'b0; init_regs = 1'b0; count_enabled = 1'b0; split = 1'b0; recall = 1'b0;
    time_in = 16'h0123;

    //            ce  sp  rc  ini  time      disp      idx cnt frz rec
    vecs.push_back(mkv(0, 0, 0, 0, 16'h0123, 16'h0123, 0, 0, 0, 0)); // first cycle after release
    vecs.push_back(mkv(0, 0, 1, 0, 16'h0124, 16'h0124, 0, 0, 0, 0)); // recall with no laps
    vecs.push_back(mkv(0, 1, 0, 0, 16'h0125, 16'h0125, 0, 0, 0, 0)); // split while paused
    vecs.push_back(mkv(1, 1, 0, 0, 16'h0250, 16'h0250, 0, 1, 1, 0)); // capture
    vecs.push_back(mkv(1, 0, 0, 0, 16'h0251, 16'h0250, 0, 1, 1, 0));
    vecs.push_back(mkv(1, 0, 0, 0, 16'h0252, 16'h0250, 0, 1, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 16'h0253, 16'h0250, 0, 1, 1, 0)); // pause alone keeps FROZEN
    vecs.push_back(mkv(1, 1, 0, 0, 16'h0254, 16'h0250, 0, 1, 0, 0)); // unfreeze, no capture
    vecs.push_back(mkv(1, 0, 0, 0, 16'h0255, 16'h0255, 0, 1, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 16'h0256, 16'h0256, 0, 0, 0, 0)); // init_regs
    vecs.push_back(mkv(1, 1, 1, 0, 16'h0100, 16'h0100, 0, 1, 1, 0)); // split+recall: capture only
    vecs.push_back(mkv(1, 1, 0, 0, 16'h0101, 16'h0100, 0, 1, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 0, 16'h0200, 16'h0200, 0, 2, 1, 0));
    vecs.push_back(mkv(1, 1, 0, 0, 16'h0201, 16'h0200, 0, 2, 0, 0));
    vecs.push_back(mkv(1, 1, 0, 0, 16'h0300, 16'h0300, 0, 3, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 16'h0301, 16'h0300, 0, 3, 1, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 16'h0302, 16'h0300, 0, 3, 0, 1)); // FROZEN -> RECALL
    vecs.push_back(mkv(0, 0, 0, 0, 16'h0303, 16'h0100, 0, 3, 0, 1));
    vecs.push_back(mkv(0, 0, 1, 0, 16'h0304, 16'h0100, 1, 3, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 16'h0305, 16'h0200, 1, 3, 0, 1));
    vecs.push_back(mkv(0, 0, 1, 0, 16'h0305, 16'h0200, 2, 3, 0, 1));
    vecs.push_back(mkv(0, 0, 0, 0, 16'h0305, 16'h0300, 2, 3, 0, 1));
    vecs.push_back(mkv(0, 0, 1, 0, 16'h0306, 16'h0300, 0, 3, 0, 0)); // past last lap -> LIVE
    vecs.push_back(mkv(0, 0, 0, 0, 16'h0307, 16'h0307, 0, 3, 0, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 16'h0400, 16'h0400, 0, 3, 0, 1)); // LIVE -> RECALL
    vecs.push_back(mkv(0, 0, 1, 0, 16'h0401, 16'h0100, 1, 3, 0, 1));
    vecs.push_back(mkv(1, 0, 0, 0, 16'h0402, 16'h0200, 0, 3, 0, 0)); // resume exits RECALL
    vecs.push_back(mkv(1, 0, 0, 0, 16'h0403, 16'h0403, 0, 3, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 1, 16'h0404, 16'h0404, 0, 0, 0, 0)); // init_regs clears laps

    // Held in reset across edges: everything zero
    step();
    step();
    chk_all(-1, 16'h0000, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      count_enabled = vecs[i].ce; split = vecs[i].sp; recall = vecs[i].rc;
      init_regs = vecs[i].ini; time_in = vecs[i].t;
      step();
      chk_all(i, vecs[i].disp, vecs[i].idx, vecs[i].cnt, vecs[i].frz, vecs[i].rec, vecs[i].ovf);
    end
    init_regs = 1'b0;

    // Five captures into a four-deep buffer
    for (int k = 1; k <= 5; k++) begin
      count_enabled = 1'b1; split = 1'b1; time_in = 16'(k);
      step();
      if (k == 5) chk_all(100, 16'h0005, 2'd0, 3'd4, 1'b1, 1'b0, 1'b1);
      time_in = 16'h00f0;
      step();
    end
    split = 1'b0; count_enabled = 1'b0; time_in = 16'h0000;
    step();
`ifdef LAP_RING_EN
    exp_laps[0] = 16'h0002; exp_laps[1] = 16'h0003; exp_laps[2] = 16'h0004; exp_laps[3] = 16'h0005;
`else
    exp_laps[0] = 16'h0001; exp_laps[1] = 16'h0002; exp_laps[2] = 16'h0003; exp_laps[3] = 16'h0004;
`endif
    recall = 1'b1;
    step();
    recall = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk_all(200 + i, exp_laps[i], 2'(i), 3'd4, 1'b0, 1'b1, 1'b1);
      recall = 1'b1;
      step();
      recall = 1'b0;
      step();
    end
    chk("recalling_after_last", 204, 32'(recalling), 32'd0);
    chk("lap_idx_after_last",   204, 32'(lap_idx),   32'd0);

    // Asynchronous reset while FROZEN clears state before the next edge
    count_enabled = 1'b1; split = 1'b1; time_in = 16'h0777;
    step();
    split = 1'b0;
    chk("frozen_before_reset", 300, 32'(frozen), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk_all(301, 16'h0000, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    time_in = 16'h0888;
    step();
    chk_all(302, 16'h0888, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
